// File: rtl/f_pc_unit.sv
// f_pc_unit
// Fetch-stage program counter and next-PC selection for the five-stage MIPS
// pipeline. It takes redirect requests from the D stage (branch, j/jal,
// jr/jalr, eret) and from CP0 (exception/interrupt entry), and flags fetch
// address faults (AdEL).
//
// Ports
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   stall          : D-stage hazard stall, holds the PC
//   req            : CP0 exception/interrupt request, overrides stall
//   D_eret         : D-stage instruction is eret
//   EPC            : eret return address
//   D_NPCOp        : 0 seq, 1 cond branch, 2 j/jal, 3 jr/jalr
//   D_b_jump       : branch condition outcome
//   D_PC           : PC of the D-stage instruction
//   D_imm16        : branch word offset
//   D_imm26        : jump index
//   D_rs           : forwarded rs for jr/jalr
//   F_PC           : current fetch address
//   F_ExcCode      : 0 none, 4 AdEL
//   F_BD           : instruction in F is a delay slot
//   FD_clr         : flush the F-D register on the next edge
module f_pc_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_LO     = 32'h0000_3000,
    parameter logic [31:0] IM_HI     = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic [1:0]  D_NPCOp,
    input  logic        D_b_jump,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs,
    output logic [31:0] F_PC,
    output logic [4:0]  F_ExcCode,
    output logic        F_BD,
    output logic        FD_clr
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign pc_plus4  = pc_q + 32'd4;
    // Branch target is relative to the delay slot (D_PC + 4).
    assign br_target = D_PC + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign j_target  = {D_PC[31:28], D_imm26, 2'b00};

    // Priority: req > stall > eret > D_NPCOp. Reset is handled in the flop.
    always_comb begin
        pc_d = pc_plus4;
        if (req) begin
            pc_d = EXC_ENTRY;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (D_eret) begin
            pc_d = EPC;
        end else begin
            unique case (D_NPCOp)
                2'd1:    pc_d = D_b_jump ? br_target : pc_plus4;
                2'd2:    pc_d = j_target;
                2'd3:    pc_d = D_rs;
                default: pc_d = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign F_PC = pc_q;

    // Bad targets are loaded anyway; the fault is only reported here.
    assign F_ExcCode = ((pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI))
                       ? EXC_ADEL : EXC_NONE;

    assign F_BD   = (D_NPCOp != 2'd0) && !D_eret;

    // eret has no delay slot, so the sequentially fetched instruction is squashed.
    assign FD_clr = D_eret && !stall && !req;

endmodule

// File: tb/tb_f_pc_unit.sv
module tb_f_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        req;
    logic        D_eret;
    logic [31:0] EPC;
    logic [1:0]  D_NPCOp;
    logic        D_b_jump;
    logic [31:0] D_PC;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [31:0] D_rs;
    logic [31:0] F_PC;
    logic [4:0]  F_ExcCode;
    logic        F_BD;
    logic        FD_clr;

    int unsigned n_tests;
    int unsigned n_fail;
    bit          check_en;
    logic [31:0] mpc;

    f_pc_unit #(
        .PC_RESET (32'h0000_3000),
        .EXC_ENTRY(32'h0000_4180),
        .IM_LO    (32'h0000_3000),
        .IM_HI    (32'h0000_6ffc)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .req      (req),
        .D_eret   (D_eret),
        .EPC      (EPC),
        .D_NPCOp  (D_NPCOp),
        .D_b_jump (D_b_jump),
        .D_PC     (D_PC),
        .D_imm16  (D_imm16),
        .D_imm26  (D_imm26),
        .D_rs     (D_rs),
        .F_PC     (F_PC),
        .F_ExcCode(F_ExcCode),
        .F_BD     (F_BD),
        .FD_clr   (FD_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: next fetch address from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur);
        longint signed off;
        if (reset)       return 32'h3000;
        if (req)         return 32'h4180;
        if (stall)       return cur;
        if (D_eret)      return EPC;
        case (D_NPCOp)
            2'd1: begin
                if (!D_b_jump) return cur + 4;
                off = longint'($signed(D_imm16)) * 4;
                return 32'(longint'(D_PC) + 4 + off);
            end
            2'd2:    return (D_PC & 32'hf000_0000) + {6'd0, D_imm26} * 4;
            2'd3:    return D_rs;
            default: return cur + 4;
        endcase
    endfunction

    function automatic logic [4:0] model_exc(input logic [31:0] a);
        if ((a % 4) != 0 || a < 32'h3000 || a > 32'h6ffc) return 5'd4;
        return 5'd0;
    endfunction

    always @(posedge clk) begin
        mpc = model_next(mpc);
        if (reset) check_en = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("m_F_PC", F_PC, mpc);
            check("m_ExcCode", {27'd0, F_ExcCode}, {27'd0, model_exc(mpc)});
            check("m_F_BD", {31'd0, F_BD}, {31'd0, (D_NPCOp != 0) && !D_eret});
            check("m_FD_clr", {31'd0, FD_clr}, {31'd0, D_eret && !stall && !req});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; req = 0; D_eret = 0; EPC = '0;
        D_NPCOp = 2'd0; D_b_jump = 0; D_PC = '0; D_imm16 = '0; D_imm26 = '0; D_rs = '0;
    endtask

    task automatic jr(input logic [31:0] t);
        D_NPCOp = 2'd3; D_rs = t;
        cyc();
        D_NPCOp = 2'd0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; check_en = 0; mpc = '0;
        idle();
        reset = 1;
        @(negedge clk);
        cyc();
        check("rst_pc", F_PC, 32'h3000);
        check("rst_exc", {27'd0, F_ExcCode}, 32'd0);
        check("rst_bd", {31'd0, F_BD}, 32'd0);
        check("rst_clr", {31'd0, FD_clr}, 32'd0);
        reset = 0;
        cyc(); check("seq1", F_PC, 32'h3004);
        cyc(); check("seq2", F_PC, 32'h3008);
        check("seq_exc", {27'd0, F_ExcCode}, 32'd0);

        // Taken branch backwards
        D_PC = 32'h3010; D_NPCOp = 2'd1; D_imm16 = 16'hfffc; D_b_jump = 1;
        #1 check("br_bd", {31'd0, F_BD}, 32'd1);
        cyc(); check("br_taken", F_PC, 32'h3004);
        D_NPCOp = 2'd0;
        repeat (4) cyc();
        check("pc_3014", F_PC, 32'h3014);
        D_NPCOp = 2'd1; D_b_jump = 0;
        #1 check("nt_bd", {31'd0, F_BD}, 32'd1);
        cyc(); check("br_not_taken", F_PC, 32'h3018);

        // j and jr
        D_NPCOp = 2'd2; D_PC = 32'h3000; D_imm26 = 26'h0000d04;
        cyc(); check("jump", F_PC, 32'h3410);
        jr(32'h5000); check("jr", F_PC, 32'h5000);

        // Stall holds PC while a taken branch waits in D
        jr(32'h3020);
        stall = 1; D_NPCOp = 2'd1; D_b_jump = 1; D_PC = 32'h3010; D_imm16 = 16'hfffc;
        for (int i = 0; i < 3; i++) begin
            cyc(); check("stall_hold", F_PC, 32'h3020);
        end
        stall = 0;
        cyc(); check("stall_release", F_PC, 32'h3004);
        D_NPCOp = 2'd0;

        // Exception entry overrides stall
        stall = 1; req = 1;
        cyc(); check("req_stall", F_PC, 32'h4180);
        stall = 0; req = 0;
        cyc();

        // eret
        D_eret = 1; EPC = 32'h3048;
        #1 check("eret_clr", {31'd0, FD_clr}, 32'd1);
        check("eret_bd", {31'd0, F_BD}, 32'd0);
        cyc(); check("eret_pc", F_PC, 32'h3048);
        // eret wins over a (nonsensical) jump
        D_NPCOp = 2'd2; D_imm26 = 26'h1; EPC = 32'h3100;
        cyc(); check("eret_wins", F_PC, 32'h3100);
        D_NPCOp = 2'd0;
        // eret during stall: no flush, PC held
        stall = 1;
        #1 check("eret_stall_clr", {31'd0, FD_clr}, 32'd0);
        cyc(); check("eret_stall_pc", F_PC, 32'h3100);
        stall = 0;
        // req together with eret
        req = 1;
        #1 check("req_eret_clr", {31'd0, FD_clr}, 32'd0);
        cyc(); check("req_eret_pc", F_PC, 32'h4180);
        req = 0; D_eret = 0;

        // AdEL boundaries
        jr(32'h3002); check("adel_misalign", {27'd0, F_ExcCode}, 32'd4);
        jr(32'h7000); check("adel_high", {27'd0, F_ExcCode}, 32'd4);
        jr(32'h6ffc); check("ok_top", {27'd0, F_ExcCode}, 32'd0);
        cyc();        check("past_top", {27'd0, F_ExcCode}, 32'd4);
        jr(32'h2ffc); check("adel_low", {27'd0, F_ExcCode}, 32'd4);
        jr(32'h3000); check("ok_bottom", {27'd0, F_ExcCode}, 32'd0);
        // Wrap-around
        jr(32'hffff_fffc);
        cyc(); check("wrap", F_PC, 32'h0);

        // Reset beats req, stall and jr
        reset = 1; req = 1; stall = 1; D_NPCOp = 2'd3; D_rs = 32'h5000;
        cyc(); check("reset_prio", F_PC, 32'h3000);
        idle();
        cyc(); check("post_reset", F_PC, 32'h3004);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
